// File: rtl/priority_encoder_rr_if.sv
// Request/grant bundle for the registered priority encoder.
// The slave side is the encoder and the master side is its user.
interface priority_encoder_rr_if #(
  parameter int N = 8
);
  localparam int W = (N > 2) ? $clog2(N) : 1;

  logic         en;
  logic         mode;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;

  modport master (
    output en,
    output mode,
    output req,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot
  );

  modport slave (
    input  en,
    input  mode,
    input  req,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered N-input priority encoder with fixed and round-robin modes.
// The grant is held in an output register behind a valid/ready handshake.
module priority_encoder_rr #(
  parameter int N = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  priority_encoder_rr_if.slave bus
);
  localparam int W  = (N > 2) ? $clog2(N) : 1;
  localparam int WP = W + 1;

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_oh;
  logic [W-1:0] r_ptr;

  logic         w_slot;
  logic         w_any;
  logic [W-1:0] w_fix;
  logic [W-1:0] w_rr;
  logic [W-1:0] w_win;
  logic [W-1:0] w_nptr;
  logic [N-1:0] w_oh;
  logic [WP-1:0] w_inc;

  assign w_slot = !r_valid || bus.out_ready;
  assign w_any  = |bus.req;

  // Ascending scan, so the highest set index is the last to be kept.
  always_comb begin
    w_fix = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.req[k]) w_fix = W'(k);
    end
  end

  // Descending offset scan keeps the set bit closest after r_ptr.
  always_comb begin
    logic [WP-1:0] w_pos;
    w_rr  = '0;
    w_pos = '0;
    for (int o = N - 1; o >= 0; o--) begin
      w_pos = WP'(r_ptr) + WP'(o);
      if (w_pos >= WP'(N)) w_pos = w_pos - WP'(N);
      if (bus.req[w_pos[W-1:0]]) w_rr = w_pos[W-1:0];
    end
  end

  assign w_win  = bus.mode ? w_rr : w_fix;
  assign w_inc  = WP'(w_win) + WP'(1);
  assign w_nptr = (w_inc == WP'(N)) ? '0 : w_inc[W-1:0];
  assign w_oh   = {{(N-1){1'b0}}, 1'b1} << w_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_oh    <= '0;
      r_ptr   <= '0;
    end else if (bus.en && w_slot) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_idx   <= w_win;
        r_oh    <= w_oh;
        if (bus.mode) r_ptr <= w_nptr;
      end else begin
        r_valid <= 1'b0;
        r_idx   <= '0;
        r_oh    <= '0;
      end
    end else if (!bus.en && r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_oh    <= '0;
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_idx    = r_idx;
  assign bus.out_onehot = r_oh;
endmodule
